// File: rtl/demux_1x2_stream.sv
// Registered 1-to-2 stream demultiplexer: one valid/ready input is steered by sel to
// port A or B. Each port has a 2-entry skid buffer. Optional counters: DEMUX_COUNT_EN.

// One output port: main register drives the port, skid register absorbs the second
// word while the consumer stalls.
module demux_1x2_port #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             acc,
  input  logic [WIDTH-1:0] d,
  input  logic             ready,
  output logic             valid,
  output logic             full,
  output logic [WIDTH-1:0] q
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             pop;

  assign pop = valid & ready;

  // NOTE: state and data registers use non-blocking assignments so every register
  // samples pre-edge values; the data registers are reset too, so the ports read 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            state  <= ONE;
            main_q <= d;
          end
        end
        ONE: begin
          if (acc && !pop) begin
            state  <= TWO;
            skid_q <= d;
          end else if (pop && !acc) begin
            state <= EMPTY;
          end else if (acc && pop) begin
            main_q <= d;
          end
        end
        TWO: begin
          // in_ready is low for a full port, so acc cannot occur here
          if (pop) begin
            state  <= ONE;
            main_q <= skid_q;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign valid = (state != EMPTY);
  assign full  = (state == TWO);
  assign q     = main_q;

endmodule

module demux_1x2_stream #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sel,
  input  logic [WIDTH-1:0] d,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a,
  output logic             b_valid,
  input  logic             b_ready,
`ifdef DEMUX_COUNT_EN
  output logic [WIDTH-1:0] b,
  input  logic             clr_cnt,
  output logic [15:0]      cnt_a,
  output logic [15:0]      cnt_b
`else
  output logic [WIDTH-1:0] b
`endif
);

  logic a_full;
  logic b_full;
  logic acc_a;
  logic acc_b;

  // Ready depends only on the addressed port's registered state, never on the
  // consumers, so there is no ready path from a_ready/b_ready to in_ready.
  assign in_ready = sel ? !b_full : !a_full;
  assign acc_a    = in_valid & in_ready & !sel;
  assign acc_b    = in_valid & in_ready & sel;

  demux_1x2_port #(.WIDTH(WIDTH)) u_port_a (
    .clk   (clk),
    .rst_n (rst_n),
    .acc   (acc_a),
    .d     (d),
    .ready (a_ready),
    .valid (a_valid),
    .full  (a_full),
    .q     (a)
  );

  demux_1x2_port #(.WIDTH(WIDTH)) u_port_b (
    .clk   (clk),
    .rst_n (rst_n),
    .acc   (acc_b),
    .d     (d),
    .ready (b_ready),
    .valid (b_valid),
    .full  (b_full),
    .q     (b)
  );

`ifdef DEMUX_COUNT_EN
  logic pop_a;
  logic pop_b;

  assign pop_a = a_valid & a_ready;
  assign pop_b = b_valid & b_ready;

  // Clear wins over a same-cycle delivery; counters wrap naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (clr_cnt) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (pop_a) cnt_a <= cnt_a + 16'd1;
      if (pop_b) cnt_b <= cnt_b + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demux_1x2_stream.sv
// Scoreboard bench for demux_1x2_stream: accepted words are queued per port and
// compared as each port delivers them. Counter checks build with DEMUX_COUNT_EN.
module tb_demux_1x2_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sel;
  logic [31:0] d;
  logic        a_valid;
  logic        a_ready;
  logic [31:0] a;
  logic        b_valid;
  logic        b_ready;
  logic [31:0] b;
`ifdef DEMUX_COUNT_EN
  logic        clr_cnt;
  logic [15:0] cnt_a;
  logic [15:0] cnt_b;
`endif

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];

  demux_1x2_stream #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .d        (d),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a        (a),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
`ifdef DEMUX_COUNT_EN
    .b        (b),
    .clr_cnt  (clr_cnt),
    .cnt_a    (cnt_a),
    .cnt_b    (cnt_b)
`else
    .b        (b)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a falling edge; holds the word until accepted, returns at the falling
  // edge after the accepting rising edge with in_valid still high.
  task automatic send(input logic s, input logic [31:0] w, output int waits);
    sel      = s;
    d        = w;
    in_valid = 1'b1;
    waits    = 0;
    while (1) begin
      #3;
      if (in_ready) begin
        if (s) q_b.push_back(w);
        else   q_a.push_back(w);
        @(negedge clk);
        return;
      end
      waits++;
      if (waits >= 200) begin
        check("send_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor samples just before each rising edge, when the handshake is settled.
  always begin
    logic [31:0] exp;
    @(negedge clk);
    #3;
    if (rst_n) begin
      if (a_valid && a_ready) begin
        if (q_a.size() == 0) check("a_unexpected", 32'(q_a.size()), 32'd1);
        else begin
          exp = q_a.pop_front();
          check("a_data", a, exp);
        end
      end
      if (b_valid && b_ready) begin
        if (q_b.size() == 0) check("b_unexpected", 32'(q_b.size()), 32'd1);
        else begin
          exp = q_b.pop_front();
          check("b_data", b, exp);
        end
      end
    end
  end

  initial begin
    int w;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sel      = 1'b1;
    d        = '0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
`ifdef DEMUX_COUNT_EN
    clr_cnt  = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_a_valid", {31'd0, a_valid}, 32'd0);
    check("rst_b_valid", {31'd0, b_valid}, 32'd0);
    check("rst_a", a, 32'd0);
    check("rst_b", b, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef DEMUX_COUNT_EN
    check("rst_cnt_a", {16'd0, cnt_a}, 32'd0);
    check("rst_cnt_b", {16'd0, cnt_b}, 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Single word to A: visible one cycle after acceptance, then consumed.
    a_ready = 1'b1;
    b_ready = 1'b1;
    check("t1_a_valid_before", {31'd0, a_valid}, 32'd0);
    send(1'b0, 32'd1, w);
    check("t1_waits", w, 32'd0);
    check("t1_a_valid", {31'd0, a_valid}, 32'd1);
    check("t1_a", a, 32'd1);
    check("t1_b_valid", {31'd0, b_valid}, 32'd0);
    idle(1);
    check("t1_a_valid_after", {31'd0, a_valid}, 32'd0);
    check("t1_b_valid_after", {31'd0, b_valid}, 32'd0);
`ifdef DEMUX_COUNT_EN
    check("t1_cnt_a", {16'd0, cnt_a}, 32'd1);
`endif

    // Alternating destinations at full rate.
    for (int i = 0; i < 4; i++) begin
      send(i[0], 32'(2 * i + 1), w);
      check("t2_no_stall", w, 32'd0);
    end
    idle(2);
    check("t2_a_drained", 32'(q_a.size()), 32'd0);
    check("t2_b_drained", 32'(q_b.size()), 32'd0);

    // Stalled A absorbs two words; B keeps flowing; third A word stalls input.
    a_ready = 1'b0;
    send(1'b0, 32'd10, w);
    check("t3_first", w, 32'd0);
    send(1'b0, 32'd11, w);
    check("t3_second", w, 32'd0);
    send(1'b1, 32'd20, w);
    check("t3_b_word", w, 32'd0);
    sel = 1'b0;
    d   = 32'd12;
    #3;
    check("t3_stall0", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    #3;
    check("t3_stall1", {31'd0, in_ready}, 32'd0);
    check("t3_a_hold", a, 32'd10);
    @(negedge clk);
    a_ready = 1'b1;
    send(1'b0, 32'd12, w);
    check("t3_third_waited", w, 32'd1);
    idle(3);
    check("t3_a_drained", 32'(q_a.size()), 32'd0);
    check("t3_b_drained", 32'(q_b.size()), 32'd0);

    // A in ONE, accept and pop together for 8 cycles.
    send(1'b0, 32'd100, w);
    for (int i = 1; i <= 8; i++) begin
      send(1'b0, 32'(100 + i), w);
      check("t4_no_stall", w, 32'd0);
      check("t4_a_valid", {31'd0, a_valid}, 32'd1);
    end
    idle(1);
    check("t4_a_last", a, 32'd108);
    idle(1);
    check("t4_a_empty", {31'd0, a_valid}, 32'd0);

    // Asynchronous reset with both ports full.
    a_ready = 1'b0;
    b_ready = 1'b0;
    send(1'b0, 32'd30, w);
    send(1'b0, 32'd31, w);
    send(1'b1, 32'd40, w);
    send(1'b1, 32'd41, w);
    in_valid = 1'b0;
    sel      = 1'b0;
    #1;
    check("t5_a_full", {31'd0, in_ready}, 32'd0);
    sel = 1'b1;
    #1;
    check("t5_b_full", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("t5_a_valid", {31'd0, a_valid}, 32'd0);
    check("t5_b_valid", {31'd0, b_valid}, 32'd0);
    check("t5_a", a, 32'd0);
    check("t5_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef DEMUX_COUNT_EN
    check("t5_cnt_a", {16'd0, cnt_a}, 32'd0);
    check("t5_cnt_b", {16'd0, cnt_b}, 32'd0);
`endif
    q_a.delete();
    q_b.delete();
    @(negedge clk);
    rst_n   = 1'b1;
    a_ready = 1'b1;
    b_ready = 1'b1;
    @(negedge clk);
    send(1'b1, 32'd50, w);
    check("t5_post_b_valid", {31'd0, b_valid}, 32'd1);
    check("t5_post_b", b, 32'd50);
    check("t5_post_a_valid", {31'd0, a_valid}, 32'd0);
    idle(2);

`ifdef DEMUX_COUNT_EN
    // Counter wrap on B after 65536 deliveries, then clear racing a pop on A.
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    check("t6_clr", {cnt_a, cnt_b}, 32'd0);
    for (int i = 0; i < 65536; i++) send(1'b1, 32'(i), w);
    idle(2);
    check("t6_wrap", {16'd0, cnt_b}, 32'd0);
    send(1'b0, 32'd7, w);
    idle(1);
    check("t6_cnt_a_one", {16'd0, cnt_a}, 32'd1);
    send(1'b0, 32'd8, w);
    in_valid = 1'b0;
    clr_cnt  = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    check("t6_clr_pop_a", {16'd0, cnt_a}, 32'd0);
    check("t6_clr_pop_b", {16'd0, cnt_b}, 32'd0);
    idle(2);
`endif

    check("end_a_leftover", 32'(q_a.size()), 32'd0);
    check("end_b_leftover", 32'(q_b.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
